player_position_engine: RTL and testbench
=========================================

Name: player_position_engine

Overview:
- Multi-player successor to the single-player maze position datapath.
- Accepts one move request per transaction over a valid/ready handshake and computes the candidate cell with edge clamping or wrap.
- Queries the external maze-legality checker through a req/done handshake, then commits or rejects the move and updates per-player move counts (saturating, with bonus/penalty).
- Sits between the keyboard/move decoder and the VGA draw controller.

Parameters:
- NUM_PLAYERS, 2, number of independent player tokens (1..4)
- COORD_W, 5, width of each X/Y coordinate
- MAX_X, 31, largest legal X
- MAX_Y, 31, largest legal Y
- START_X, 1, reset/force-reset X for every player
- START_Y, 0, reset/force-reset Y for every player
- SCORE_W, 10, move-counter width
- BONUS, 5, magnitude of the plus/minus move adjustment
- WRAP_EN, 0, 1 = off-grid moves wrap to the opposite edge; 0 = rejected without a checker query

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- move_valid  in  1  move request present
- move_ready  out  1  engine can accept a request (high only in IDLE)
- move_player  in  PID_W=max(1,clog2(NUM_PLAYERS))  player index
- move_dir  in  2  0 left, 1 right, 2 up (Y-1), 3 down (Y+1)
- move_bonus  in  2  00 normal (+1), 01 plus BONUS, 10 minus BONUS, 11 treated as 00
- game_over  in  1  level; freezes all positions and counters
- force_reset  in  1  synchronous level; returns all players to start
- chk_req  out  1  legality query, held until chk_done
- chk_x, chk_y  out  COORD_W  candidate cell, stable while chk_req
- chk_done  in  1  one-cycle checker response strobe
- chk_legal  in  1  valid with chk_done
- pos_x, pos_y  out  NUM_PLAYERS*COORD_W  current position, player p at [p*COORD_W +: COORD_W]
- prev_x, prev_y  out  NUM_PLAYERS*COORD_W  position before the last commit (for erase)
- moves  out  NUM_PLAYERS*SCORE_W  per-player move count
- upd_valid  out  1  one-cycle pulse: request finished
- upd_player  out  PID_W  player of the finished request
- upd_accepted  out  1  with upd_valid: 1 = committed

Behaviour:
- Reset (asynchronous): pos/prev = START for all players; moves = 0; state IDLE; chk_req = 0; upd_valid = 0; upd_player = 0; upd_accepted = 0; chk_x/chk_y = 0.
- FSM: IDLE, CHECK, RESP.
- IDLE:
  - move_ready = 1. Handshake on move_valid & move_ready: latch player, dir, bonus; compute the candidate.
  - Go to RESP with reject if any of: game_over = 1, player >= NUM_PLAYERS, or the candidate is off-grid with WRAP_EN = 0. Otherwise go to CHECK.
- Edge arithmetic:
  - Left at X = 0 wraps to MAX_X. Right at MAX_X wraps to 0. Y likewise.
  - Arithmetic is done modulo the range, never COORD_W overflow.
- CHECK:
  - chk_req = 1, with chk_x/chk_y = candidate; both held until chk_done.
  - No timeout. Latency from accept is 1 cycle minimum plus checker latency.
  - On chk_done, go to RESP with the result = chk_legal, sampled in that same cycle.
- RESP (one cycle):
  - upd_valid = 1.
  - If accepted: prev = old pos and pos = candidate, visible in the same cycle as upd_valid.
  - Move count is updated for every processed request except game_over/invalid-player rejects.
    - normal: +1
    - plus: +BONUS, applied only if accepted; otherwise +1
    - minus: -BONUS, applied only if accepted; otherwise +1
  - Counters saturate at 0 and at 2^SCORE_W-1.
  - Next state IDLE.
- Rejects leave pos/prev unchanged.
- force_reset:
  - Highest priority, any state: all pos/prev = START, moves = 0, state IDLE, chk_req dropped, upd_valid = 0.
  - A chk_done arriving while in IDLE is ignored.
  - move_ready = 0 while force_reset is high.
- game_over rising mid-CHECK: the query completes, but the result is forced to reject and the count is not updated.
- Simultaneous move_valid and chk_done cannot occur in the same state; no queueing, single outstanding request.

Decomposition:
- Shared package maze_pkg holds:
  - direction encodings DIR_LEFT..DIR_DOWN
  - bonus encodings
  - state encodings
  - START_X/START_Y defaults, shared with the VGA drawer
- One sub-module, position_step: purely combinational candidate/off-grid computation (dir, WRAP_EN, MAX_X/MAX_Y). It is reused by the AI-opponent block.

Test Plan:
- Reset, NUM_PLAYERS=2 -> pos_x = {1,1}, pos_y = {0,0}, moves = 0, move_ready = 1.
- P0 down, checker returns legal after 3 cycles -> chk_req high 3 cycles with chk=(1,1); upd_accepted = 1; pos0 = (1,1), prev0 = (1,0), moves0 = 1.
- P1 up at Y=0, WRAP_EN=0 -> no chk_req; upd_valid with upd_accepted = 0 one cycle later; moves1 = 1. Same with WRAP_EN=1 -> chk_y = 31.
- P0 minus bonus, legal, moves0 = 3 -> moves0 = 0 (saturate). Plus bonus, illegal -> moves0 = 1 and pos unchanged.
- force_reset asserted during CHECK -> chk_req drops next edge; all positions = (1,0), moves = 0; a late chk_done is ignored.
- game_over = 1, move request -> immediate reject, no count change; move_player = 3 with NUM_PLAYERS=2 -> reject.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared maze-game encodings and defaults used by the position engine,
// the VGA drawer and the AI-opponent block.
package maze_pkg;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        BONUS_NONE  = 2'd0,
        BONUS_PLUS  = 2'd1,
        BONUS_MINUS = 2'd2,
        BONUS_RSVD  = 2'd3
    } bonus_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_RESP  = 2'd2
    } state_e;

    localparam int START_X_DEF = 1;
    localparam int START_Y_DEF = 0;

    // Player-index width: never narrower than one bit.
    function automatic int pid_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/player_position_engine_if.sv
// Move-request, legality-checker and update-notification signals of the
// position engine; the engine is the slave, its environment the master.
interface player_position_engine_if #(
    parameter int PID_W   = 1,
    parameter int COORD_W = 5
);
    logic               move_valid;
    logic               move_ready;
    logic [PID_W-1:0]   move_player;
    logic [1:0]         move_dir;
    logic [1:0]         move_bonus;

    logic               chk_req;
    logic [COORD_W-1:0] chk_x;
    logic [COORD_W-1:0] chk_y;
    logic               chk_done;
    logic               chk_legal;

    logic               upd_valid;
    logic [PID_W-1:0]   upd_player;
    logic               upd_accepted;

    modport master (
        output move_valid, move_player, move_dir, move_bonus, chk_done, chk_legal,
        input  move_ready, chk_req, chk_x, chk_y, upd_valid, upd_player, upd_accepted
    );

    modport slave (
        input  move_valid, move_player, move_dir, move_bonus, chk_done, chk_legal,
        output move_ready, chk_req, chk_x, chk_y, upd_valid, upd_player, upd_accepted
    );
endinterface

// File: rtl/position_step.sv
// Combinational one-cell step: candidate cell for a direction, wrapping at the
// grid edges or (without wrap) holding position and flagging the move off-grid.
module position_step
    import maze_pkg::*;
#(
    parameter int COORD_W = 5,
    parameter int MAX_X   = 31,
    parameter int MAX_Y   = 31,
    parameter bit WRAP_EN = 1'b0
) (
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  dir_e               i_dir,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_off_grid
);
    localparam logic [COORD_W-1:0] MAX_XC = COORD_W'(MAX_X);
    localparam logic [COORD_W-1:0] MAX_YC = COORD_W'(MAX_Y);
    localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);

    logic w_edge;

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        o_x    = i_x;
        o_y    = i_y;
        w_edge = 1'b0;
        case (i_dir)
            DIR_LEFT:  if (i_x == '0)     begin o_x = MAX_XC; w_edge = 1'b1; end
                       else                     o_x = i_x - ONE;
            DIR_RIGHT: if (i_x >= MAX_XC) begin o_x = '0;     w_edge = 1'b1; end
                       else                     o_x = i_x + ONE;
            DIR_UP:    if (i_y == '0)     begin o_y = MAX_YC; w_edge = 1'b1; end
                       else                     o_y = i_y - ONE;
            DIR_DOWN:  if (i_y >= MAX_YC) begin o_y = '0;     w_edge = 1'b1; end
                       else                     o_y = i_y + ONE;
        endcase
        if (!WRAP_EN && w_edge) begin
            o_x = i_x;
            o_y = i_y;
        end
    end

    assign o_off_grid = w_edge && !WRAP_EN;

endmodule

// File: rtl/player_position_engine.sv
// Multi-player position engine: accepts one move at a time, queries the maze
// legality checker, then commits or rejects and updates the move counters.
module player_position_engine
    import maze_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int COORD_W     = 5,
    parameter int MAX_X       = 31,
    parameter int MAX_Y       = 31,
    parameter int START_X     = START_X_DEF,
    parameter int START_Y     = START_Y_DEF,
    parameter int SCORE_W     = 10,
    parameter int BONUS       = 5,
    parameter bit WRAP_EN     = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_game_over,
    input  logic                             i_force_reset,
    player_position_engine_if.slave          bus,
    output logic [NUM_PLAYERS*COORD_W-1:0]   o_pos_x,
    output logic [NUM_PLAYERS*COORD_W-1:0]   o_pos_y,
    output logic [NUM_PLAYERS*COORD_W-1:0]   o_prev_x,
    output logic [NUM_PLAYERS*COORD_W-1:0]   o_prev_y,
    output logic [NUM_PLAYERS*SCORE_W-1:0]   o_moves
);
    localparam int                 PID_W     = pid_width(NUM_PLAYERS);
    localparam logic [COORD_W-1:0] START_XC  = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] START_YC  = COORD_W'(START_Y);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [SCORE_W-1:0] BONUS_C   = SCORE_W'(BONUS);

    state_e             r_state, w_next_state;
    logic [COORD_W-1:0] r_pos_x  [NUM_PLAYERS];
    logic [COORD_W-1:0] r_pos_y  [NUM_PLAYERS];
    logic [COORD_W-1:0] r_prev_x [NUM_PLAYERS];
    logic [COORD_W-1:0] r_prev_y [NUM_PLAYERS];
    logic [SCORE_W-1:0] r_moves  [NUM_PLAYERS];
    logic [PID_W-1:0]   r_player;
    bonus_e             r_bonus;
    logic [COORD_W-1:0] r_cand_x, r_cand_y;
    logic               r_frozen;
    logic               r_accept;

    logic               w_handshake, w_player_ok, w_off_grid;
    logic [COORD_W-1:0] w_cur_x, w_cur_y, w_cand_x, w_cand_y;
    logic [PID_W-1:0]   w_tgt_player;
    logic               w_commit, w_count_en, w_result_ok;

    assign w_handshake  = bus.move_valid && bus.move_ready;
    assign w_player_ok  = int'(bus.move_player) < NUM_PLAYERS;
    assign w_tgt_player = (r_state == S_IDLE) ? bus.move_player : r_player;

    // Out-of-range player indices fall back to player 0; they are rejected anyway.
    always_comb begin
        w_cur_x = r_pos_x[0];
        w_cur_y = r_pos_y[0];
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (int'(bus.move_player) == p) begin
                w_cur_x = r_pos_x[p];
                w_cur_y = r_pos_y[p];
            end
        end
    end

    position_step #(
        .COORD_W (COORD_W),
        .MAX_X   (MAX_X),
        .MAX_Y   (MAX_Y),
        .WRAP_EN (WRAP_EN)
    ) u_step (
        .i_x        (w_cur_x),
        .i_y        (w_cur_y),
        .i_dir      (dir_e'(bus.move_dir)),
        .o_x        (w_cand_x),
        .o_y        (w_cand_y),
        .o_off_grid (w_off_grid)
    );

    function automatic logic [SCORE_W-1:0] next_count(input logic [SCORE_W-1:0] cur,
                                                      input logic use_bonus,
                                                      input bonus_e b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, cur} + (SCORE_W+1)'(1);
        if (use_bonus && b == BONUS_MINUS)
            return (cur < BONUS_C) ? '0 : cur - BONUS_C;
        if (use_bonus && b == BONUS_PLUS)
            sum = {1'b0, cur} + {1'b0, BONUS_C};
        return sum[SCORE_W] ? SCORE_MAX : sum[SCORE_W-1:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_commit     = 1'b0;
        w_count_en   = 1'b0;
        w_result_ok  = 1'b0;
        case (r_state)
            S_IDLE: if (w_handshake) begin
                if (i_game_over || !w_player_ok) begin
                    w_next_state = S_RESP;
                end else if (w_off_grid) begin
                    w_next_state = S_RESP;
                    w_count_en   = 1'b1;
                end else begin
                    w_next_state = S_CHECK;
                end
            end
            S_CHECK: if (bus.chk_done) begin
                w_next_state = S_RESP;
                w_count_en   = !(i_game_over || r_frozen);
                w_result_ok  = bus.chk_legal && w_count_en;
                w_commit     = w_result_ok;
            end
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        if (i_force_reset) begin
            w_next_state = S_IDLE;
            w_commit     = 1'b0;
            w_count_en   = 1'b0;
        end
    end

    // Request context: captured on accept, game_over made sticky while checking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_player <= '0;
            r_bonus  <= BONUS_NONE;
            r_cand_x <= '0;
            r_cand_y <= '0;
            r_frozen <= 1'b0;
            r_accept <= 1'b0;
        end else begin
            if (w_handshake) begin
                r_player <= bus.move_player;
                r_bonus  <= bonus_e'(bus.move_bonus);
                r_cand_x <= w_cand_x;
                r_cand_y <= w_cand_y;
                r_frozen <= 1'b0;
            end else if (r_state == S_CHECK) begin
                r_frozen <= r_frozen || i_game_over;
            end
            if (r_state != S_RESP) r_accept <= w_result_ok;
        end
    end

    // NOTE: the per-player arrays are small register files, so they take the
    // async reset like any other state; nothing here maps to RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                r_pos_x[p]  <= START_XC;
                r_pos_y[p]  <= START_YC;
                r_prev_x[p] <= START_XC;
                r_prev_y[p] <= START_YC;
                r_moves[p]  <= '0;
            end
        end else if (i_force_reset) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                r_pos_x[p]  <= START_XC;
                r_pos_y[p]  <= START_YC;
                r_prev_x[p] <= START_XC;
                r_prev_y[p] <= START_YC;
                r_moves[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (int'(w_tgt_player) == p) begin
                    if (w_commit) begin
                        r_prev_x[p] <= r_pos_x[p];
                        r_prev_y[p] <= r_pos_y[p];
                        r_pos_x[p]  <= r_cand_x;
                        r_pos_y[p]  <= r_cand_y;
                    end
                    if (w_count_en) r_moves[p] <= next_count(r_moves[p], w_commit, r_bonus);
                end
            end
        end
    end

    assign bus.move_ready   = (r_state == S_IDLE) && !i_force_reset;
    assign bus.chk_req      = (r_state == S_CHECK);
    assign bus.chk_x        = r_cand_x;
    assign bus.chk_y        = r_cand_y;
    assign bus.upd_valid    = (r_state == S_RESP);
    assign bus.upd_player   = r_player;
    assign bus.upd_accepted = r_accept;

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pack
        assign o_pos_x [g*COORD_W +: COORD_W] = r_pos_x[g];
        assign o_pos_y [g*COORD_W +: COORD_W] = r_pos_y[g];
        assign o_prev_x[g*COORD_W +: COORD_W] = r_prev_x[g];
        assign o_prev_y[g*COORD_W +: COORD_W] = r_prev_y[g];
        assign o_moves [g*SCORE_W +: SCORE_W] = r_moves[g];
    end

endmodule

// File: tb/tb_player_position_engine.sv
// Bench for player_position_engine: a clamping 2-player instance and a wrapping
// 3-player instance, checked against a plain-arithmetic model of the game rules.
module tb_player_position_engine;
    import maze_pkg::*;

    localparam int CW   = 5;
    localparam int SW   = 10;
    localparam int NP   = 2;
    localparam int NPW  = 3;
    localparam int MAXV = 31;
    localparam int MAXC = 1023;
    localparam int BON  = 5;

    logic clk = 1'b0;
    logic rst;
    logic game_over, force_reset, game_over_w, force_reset_w;
    always #5 clk = ~clk;

    player_position_engine_if #(.PID_W(1), .COORD_W(CW)) ifa ();
    player_position_engine_if #(.PID_W(2), .COORD_W(CW)) ifw ();

    logic [NP*CW-1:0]  pos_x, pos_y, prev_x, prev_y;
    logic [NP*SW-1:0]  moves;
    logic [NPW*CW-1:0] wpos_x, wpos_y, wprev_x, wprev_y;
    logic [NPW*SW-1:0] wmoves;

    player_position_engine #(
        .NUM_PLAYERS(NP), .COORD_W(CW), .MAX_X(MAXV), .MAX_Y(MAXV), .START_X(1), .START_Y(0),
        .SCORE_W(SW), .BONUS(BON), .WRAP_EN(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .i_game_over(game_over), .i_force_reset(force_reset), .bus(ifa),
        .o_pos_x(pos_x), .o_pos_y(pos_y), .o_prev_x(prev_x), .o_prev_y(prev_y), .o_moves(moves)
    );

    player_position_engine #(
        .NUM_PLAYERS(NPW), .COORD_W(CW), .MAX_X(MAXV), .MAX_Y(MAXV), .START_X(1), .START_Y(0),
        .SCORE_W(SW), .BONUS(BON), .WRAP_EN(1'b1)
    ) dut_w (
        .clk(clk), .rst(rst), .i_game_over(game_over_w), .i_force_reset(force_reset_w), .bus(ifw),
        .o_pos_x(wpos_x), .o_pos_y(wpos_y), .o_prev_x(wprev_x), .o_prev_y(wprev_y), .o_moves(wmoves)
    );

    int errors, checks;
    int m_px[NP], m_py[NP], m_prx[NP], m_pry[NP], m_mv[NP];
    int mw_px[NPW], mw_py[NPW], mw_mv[NPW];

    function automatic int sat(input int v);
        return (v < 0) ? 0 : (v > MAXC) ? MAXC : v;
    endfunction

    // Reference step: move one cell, then either wrap modulo the grid or stay put.
    function automatic void step(input int x, input int y, input int d, input bit wrap,
                                 output int nx, output int ny, output bit off);
        nx = x; ny = y;
        case (d)
            0: nx = x - 1;
            1: nx = x + 1;
            2: ny = y - 1;
            default: ny = y + 1;
        endcase
        off = (nx < 0) || (nx > MAXV) || (ny < 0) || (ny > MAXV);
        if (wrap) begin
            nx = (nx + MAXV + 1) % (MAXV + 1);
            ny = (ny + MAXV + 1) % (MAXV + 1);
            off = 1'b0;
        end else if (off) begin
            nx = x; ny = y;
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NP; i++) begin
            m_px[i] = 1; m_py[i] = 0; m_prx[i] = 1; m_pry[i] = 0; m_mv[i] = 0;
        end
    endfunction

    // One transaction on the clamping instance; starts and ends just after a negedge.
    task automatic do_move(input int p, input int d, input int b, input int lat,
                           input bit legal, input bit go_mid);
        int nx, ny;
        bit off, direct, acc, counted, go_start;
        step(m_px[p], m_py[p], d, 1'b0, nx, ny, off);
        go_start = game_over;
        direct   = go_start || off;
        ifa.move_valid  = 1'b1;
        ifa.move_player = 1'(p);
        ifa.move_dir    = 2'(d);
        ifa.move_bonus  = 2'(b);
        checks++;
        if (ifa.move_ready !== 1'b1) begin
            errors++; $display("FAIL move_ready_idle: got %b want 1", ifa.move_ready);
        end
        @(posedge clk); #1;
        ifa.move_valid = 1'b0;
        if (!direct) begin
            for (int k = 1; k <= lat; k++) begin
                @(negedge clk);
                checks++;
                if (ifa.chk_req !== 1'b1 || ifa.chk_x !== CW'(nx) || ifa.chk_y !== CW'(ny)) begin
                    errors++;
                    $display("FAIL chk_query cyc%0d: req=%b x=%0d y=%0d want req=1 x=%0d y=%0d",
                             k, ifa.chk_req, ifa.chk_x, ifa.chk_y, nx, ny);
                end
                if (k == 1 && go_mid) game_over = 1'b1;
                if (k == lat) begin ifa.chk_done = 1'b1; ifa.chk_legal = legal; end
            end
            @(posedge clk); #1;
            ifa.chk_done = 1'b0; ifa.chk_legal = 1'b0;
        end
        acc     = !direct && legal && !go_mid;
        counted = !go_start && !go_mid;
        if (acc) begin
            m_prx[p] = m_px[p]; m_pry[p] = m_py[p];
            m_px[p]  = nx;      m_py[p]  = ny;
            case (b)
                1:       m_mv[p] = sat(m_mv[p] + BON);
                2:       m_mv[p] = sat(m_mv[p] - BON);
                default: m_mv[p] = sat(m_mv[p] + 1);
            endcase
        end else if (counted) begin
            m_mv[p] = sat(m_mv[p] + 1);
        end
        @(negedge clk);
        checks++;
        if (ifa.upd_valid !== 1'b1 || ifa.upd_accepted !== acc || ifa.upd_player !== 1'(p) ||
            ifa.chk_req !== 1'b0) begin
            errors++;
            $display("FAIL upd: valid=%b acc=%b pl=%0d req=%b want valid=1 acc=%b pl=%0d req=0",
                     ifa.upd_valid, ifa.upd_accepted, ifa.upd_player, ifa.chk_req, acc, p);
        end
        for (int i = 0; i < NP; i++) begin
            checks++;
            if (pos_x[i*CW +: CW] !== CW'(m_px[i]) || pos_y[i*CW +: CW] !== CW'(m_py[i]) ||
                prev_x[i*CW +: CW] !== CW'(m_prx[i]) || prev_y[i*CW +: CW] !== CW'(m_pry[i]) ||
                moves[i*SW +: SW] !== SW'(m_mv[i])) begin
                errors++;
                $display("FAIL state p%0d: pos=(%0d,%0d) prev=(%0d,%0d) moves=%0d want pos=(%0d,%0d) prev=(%0d,%0d) moves=%0d",
                         i, pos_x[i*CW +: CW], pos_y[i*CW +: CW], prev_x[i*CW +: CW],
                         prev_y[i*CW +: CW], moves[i*SW +: SW],
                         m_px[i], m_py[i], m_prx[i], m_pry[i], m_mv[i]);
            end
        end
        if (go_mid) game_over = 1'b0;
        @(negedge clk);
        checks++;
        if (ifa.upd_valid !== 1'b0 || ifa.move_ready !== 1'b1) begin
            errors++;
            $display("FAIL upd_one_cycle: valid=%b ready=%b want valid=0 ready=1",
                     ifa.upd_valid, ifa.move_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if (ifa.chk_req !== 1'b0 || ifa.upd_valid !== 1'b0 || ifa.upd_player !== 1'b0 ||
            ifa.upd_accepted !== 1'b0 || ifa.chk_x !== 5'd0 || ifa.chk_y !== 5'd0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b upd=%b pl=%0d acc=%b chk=(%0d,%0d) want all 0",
                     ifa.chk_req, ifa.upd_valid, ifa.upd_player, ifa.upd_accepted, ifa.chk_x, ifa.chk_y);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_reset();
        for (int i = 0; i < NP; i++) begin
            checks++;
            if (pos_x[i*CW +: CW] !== 5'd1 || pos_y[i*CW +: CW] !== 5'd0 || moves[i*SW +: SW] !== 10'd0) begin
                errors++;
                $display("FAIL reset_state p%0d: pos=(%0d,%0d) moves=%0d want (1,0) 0",
                         i, pos_x[i*CW +: CW], pos_y[i*CW +: CW], moves[i*SW +: SW]);
            end
        end
        checks++;
        if (ifa.move_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", ifa.move_ready);
        end
    endtask

    task automatic test_basic();
        do_move(0, 3, 0, 3, 1'b1, 1'b0);
    endtask

    task automatic test_offgrid();
        do_move(1, 2, 0, 1, 1'b1, 1'b0);
        do_move(1, 0, 1, 1, 1'b1, 1'b0);
    endtask

    task automatic test_bonus();
        do_move(0, 1, 0, 1, 1'b1, 1'b0);
        do_move(0, 0, 3, 2, 1'b1, 1'b0);
        do_move(0, 3, 2, 1, 1'b1, 1'b0);
        do_move(0, 1, 1, 2, 1'b0, 1'b0);
    endtask

    task automatic test_game_over();
        game_over = 1'b1;
        do_move(0, 1, 1, 1, 1'b1, 1'b0);
        do_move(1, 3, 0, 1, 1'b1, 1'b0);
        game_over = 1'b0;
        do_move(1, 3, 1, 2, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            do_move($urandom_range(0, NP-1), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(1, 4), $urandom_range(0, 3) != 0, 1'b0);
        end
    endtask

    task automatic test_saturate_high();
        for (int n = 0; n < 230; n++) begin
            do_move(0, (m_px[0] < MAXV) ? 1 : 0, 1, 1, 1'b1, 1'b0);
        end
        checks++;
        if (moves[0 +: SW] !== 10'd1023) begin
            errors++; $display("FAIL saturate_high: got %0d want 1023", moves[0 +: SW]);
        end
    endtask

    task automatic test_force_reset();
        ifa.move_valid  = 1'b1;
        ifa.move_player = 1'b0;
        ifa.move_dir    = (m_px[0] < MAXV) ? 2'd1 : 2'd0;
        ifa.move_bonus  = 2'd0;
        @(posedge clk); #1;
        ifa.move_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ifa.chk_req !== 1'b1) begin
            errors++; $display("FAIL force_pre_req: got %b want 1", ifa.chk_req);
        end
        force_reset = 1'b1;
        #1;
        checks++;
        if (ifa.move_ready !== 1'b0) begin
            errors++; $display("FAIL force_ready: got %b want 0", ifa.move_ready);
        end
        @(negedge clk);
        model_reset();
        checks++;
        if (ifa.chk_req !== 1'b0 || ifa.move_ready !== 1'b0) begin
            errors++; $display("FAIL force_drop: req=%b ready=%b want 0 0", ifa.chk_req, ifa.move_ready);
        end
        for (int i = 0; i < NP; i++) begin
            checks++;
            if (pos_x[i*CW +: CW] !== 5'd1 || pos_y[i*CW +: CW] !== 5'd0 || prev_x[i*CW +: CW] !== 5'd1 ||
                prev_y[i*CW +: CW] !== 5'd0 || moves[i*SW +: SW] !== 10'd0) begin
                errors++;
                $display("FAIL force_state p%0d: pos=(%0d,%0d) prev=(%0d,%0d) moves=%0d want (1,0) (1,0) 0",
                         i, pos_x[i*CW +: CW], pos_y[i*CW +: CW], prev_x[i*CW +: CW],
                         prev_y[i*CW +: CW], moves[i*SW +: SW]);
            end
        end
        force_reset   = 1'b0;
        ifa.chk_done  = 1'b1;
        ifa.chk_legal = 1'b1;
        @(posedge clk); #1;
        ifa.chk_done = 1'b0; ifa.chk_legal = 1'b0;
        @(negedge clk);
        checks++;
        if (ifa.upd_valid !== 1'b0 || ifa.chk_req !== 1'b0 || ifa.move_ready !== 1'b1 ||
            pos_x[0 +: CW] !== 5'd1 || pos_y[0 +: CW] !== 5'd0 || moves[0 +: SW] !== 10'd0) begin
            errors++;
            $display("FAIL late_done: upd=%b req=%b ready=%b pos0=(%0d,%0d) moves0=%0d want 0 0 1 (1,0) 0",
                     ifa.upd_valid, ifa.chk_req, ifa.move_ready, pos_x[0 +: CW], pos_y[0 +: CW], moves[0 +: SW]);
        end
        do_move(0, 3, 0, 1, 1'b1, 1'b0);
    endtask

    // One transaction on the wrapping 3-player instance.
    task automatic wmove(input int p, input int d, input bit legal);
        int nx, ny;
        bit off, valid, acc;
        valid = (p < NPW);
        nx = 0; ny = 0;
        if (valid) step(mw_px[p], mw_py[p], d, 1'b1, nx, ny, off);
        ifw.move_valid  = 1'b1;
        ifw.move_player = 2'(p);
        ifw.move_dir    = 2'(d);
        ifw.move_bonus  = 2'd0;
        @(posedge clk); #1;
        ifw.move_valid = 1'b0;
        if (valid) begin
            @(negedge clk);
            checks++;
            if (ifw.chk_req !== 1'b1 || ifw.chk_x !== CW'(nx) || ifw.chk_y !== CW'(ny)) begin
                errors++;
                $display("FAIL wrap_query p%0d: req=%b x=%0d y=%0d want req=1 x=%0d y=%0d",
                         p, ifw.chk_req, ifw.chk_x, ifw.chk_y, nx, ny);
            end
            ifw.chk_done = 1'b1; ifw.chk_legal = legal;
            @(posedge clk); #1;
            ifw.chk_done = 1'b0; ifw.chk_legal = 1'b0;
        end
        acc = valid && legal;
        if (valid) begin
            if (acc) begin mw_px[p] = nx; mw_py[p] = ny; end
            mw_mv[p] = sat(mw_mv[p] + 1);
        end
        @(negedge clk);
        checks++;
        if (ifw.upd_valid !== 1'b1 || ifw.upd_accepted !== acc || ifw.upd_player !== 2'(p) ||
            ifw.chk_req !== 1'b0) begin
            errors++;
            $display("FAIL wrap_upd p%0d: valid=%b acc=%b pl=%0d req=%b want valid=1 acc=%b req=0",
                     p, ifw.upd_valid, ifw.upd_accepted, ifw.upd_player, ifw.chk_req, acc);
        end
        for (int i = 0; i < NPW; i++) begin
            checks++;
            if (wpos_x[i*CW +: CW] !== CW'(mw_px[i]) || wpos_y[i*CW +: CW] !== CW'(mw_py[i]) ||
                wmoves[i*SW +: SW] !== SW'(mw_mv[i])) begin
                errors++;
                $display("FAIL wrap_state p%0d: pos=(%0d,%0d) moves=%0d want pos=(%0d,%0d) moves=%0d",
                         i, wpos_x[i*CW +: CW], wpos_y[i*CW +: CW], wmoves[i*SW +: SW],
                         mw_px[i], mw_py[i], mw_mv[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (ifw.upd_valid !== 1'b0) begin
            errors++; $display("FAIL wrap_one_cycle: got %b want 0", ifw.upd_valid);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < NPW; i++) begin mw_px[i] = 1; mw_py[i] = 0; mw_mv[i] = 0; end
        wmove(1, 2, 1'b1);
        wmove(2, 0, 1'b1);
        wmove(2, 0, 1'b1);
        wmove(2, 1, 1'b1);
        wmove(3, 1, 1'b1);
        wmove(0, 3, 1'b0);
        for (int n = 0; n < 20; n++) wmove($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1) == 1);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        game_over = 1'b0; force_reset = 1'b0; game_over_w = 1'b0; force_reset_w = 1'b0;
        ifa.move_valid = 1'b0; ifa.move_player = '0; ifa.move_dir = '0; ifa.move_bonus = '0;
        ifa.chk_done = 1'b0; ifa.chk_legal = 1'b0;
        ifw.move_valid = 1'b0; ifw.move_player = '0; ifw.move_dir = '0; ifw.move_bonus = '0;
        ifw.chk_done = 1'b0; ifw.chk_legal = 1'b0;
        test_reset();
        test_basic();
        test_offgrid();
        test_bonus();
        test_game_over();
        test_random();
        test_saturate_high();
        test_force_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
